// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the bit-serial frame receiver.
// Optional parity support is selected by SERIAL_FRAME_RX_PARITY_EN in the users.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Counter must be able to hold DATA_W itself, not just DATA_W-1.
   function automatic int cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/serial_frame_rx_buf.sv
// One-entry valid/ready holding register for received words, with a sticky
// overrun flag set when a word arrives while the entry is full and not draining.
module serial_frame_rx_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ready_i,
   output logic [DATA_W-1:0] q_o,
   output logic              valid_o,
   output logic              overrun_o
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;
   logic              drain;

   always_comb begin
      drain   = valid_q && ready_i;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      // A load at the draining edge replaces the word and keeps valid high.
      if (load_i) begin
         if (!valid_q || drain) begin
            data_d  = data_i;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign q_o       = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start bit, DATA_W bits LSB-first, stop bit.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit before the stop bit.
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   input  logic              q_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = cnt_width(DATA_W);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              frame_err_q, frame_err_d;
   logic              good_frame;
   logic              stop_ok;

`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic              par_err_q, par_err_d;
   assign stop_ok = !par_err_q;
`else
   assign stop_ok = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      frame_err_d = 1'b0;
      good_frame  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_err_d   = par_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (d == START_LEVEL) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            // Shifting right DATA_W times lands the first bit in the LSB.
            shreg_d = {d, shreg_q[DATA_W-1:1]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef SERIAL_FRAME_RX_PARITY_EN
         PARITY: begin
            par_err_d = (d != ^shreg_q);
            state_d   = STOP;
         end
`endif
         STOP: begin
            // A bad stop bit is consumed here; the search for a start bit resumes next edge.
            state_d = IDLE;
            if (d == STOP_LEVEL && stop_ok) begin
               good_frame = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   serial_frame_rx_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .load_i    (good_frame),
      .data_i    (shreg_q),
      .ready_i   (q_ready),
      .q_o       (q),
      .valid_o   (q_valid),
      .overrun_o (overrun)
   );

   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed and randomized frames checked against a frame-level reference model.
// Parity frames are exercised when SERIAL_FRAME_RX_PARITY_EN is defined.
module tb_serial_frame_rx;

   localparam int DATA_W = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int FRAME_LEN = DATA_W + 2 + PAR_EN;

   logic              clk;
   logic              rst_n;
   logic              d;
   logic [DATA_W-1:0] q;
   logic              q_valid;
   logic              q_ready;
   logic              frame_err;
   logic              overrun;
   logic              busy;

   serial_frame_rx #(
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (d),
      .q         (q),
      .q_valid   (q_valid),
      .q_ready   (q_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Frame-level reference: what the consumer should see after each frame.
   logic [DATA_W-1:0] m_q;
   logic              m_valid;
   logic              m_ov;
   int                last_valid_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         d = 1'b1;
         tick();
         if (q_ready) m_valid = 1'b0;
         check("idle_valid", 32'(q_valid), 32'(m_valid));
         check("idle_ferr", 32'(frame_err), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_ovr", 32'(overrun), 32'(m_ov));
      end
   endtask

   // flip inverts the parity bit (ignored without parity); r is q_ready for the whole frame.
   task automatic run_frame(input logic [DATA_W-1:0] data, input logic stop,
                            input logic flip, input logic r);
      logic good;
      good    = stop && !(PAR_EN == 1 && flip);
      q_ready = r;
      d       = 1'b0;
      tick();
      if (r) m_valid = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_valid", 32'(q_valid), 32'(m_valid));
      check("start_ferr", 32'(frame_err), 32'd0);
      for (int i = 0; i < DATA_W; i++) begin
         d = data[i];
         tick();
      end
      if (PAR_EN == 1) begin
         d = (^data) ^ flip;
         tick();
      end
      d = stop;
      tick();
      if (good) begin
         if (!m_valid) begin
            m_q     = data;
            m_valid = 1'b1;
         end else begin
            m_ov = 1'b1;
         end
      end
      check("stop_ferr", 32'(frame_err), 32'(!good));
      check("stop_valid", 32'(q_valid), 32'(m_valid));
      check("stop_q", 32'(q), 32'(m_q));
      check("stop_ovr", 32'(overrun), 32'(m_ov));
      check("stop_busy", 32'(busy), 32'd0);
      if (q_valid === 1'b1) last_valid_cyc = cyc;
      d = 1'b1;
   endtask

   initial begin
      int c1;
      logic [DATA_W-1:0] rd;
      logic rs, rf, rr;

      rst_n   = 1'b0;
      d       = 1'b1;
      q_ready = 1'b0;
      m_q     = '0;
      m_valid = 1'b0;
      m_ov    = 1'b0;
      last_valid_cyc = 0;
      repeat (2) tick();
      check("rst_q", 32'(q), 32'd0);
      check("rst_valid", 32'(q_valid), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      // Basic frame after a short idle, valid for exactly one cycle
      q_ready = 1'b1;
      idle(3);
      run_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      idle(1);

      // Back-to-back frames with no idle gap
      run_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      c1 = last_valid_cyc;
      run_frame(8'hC3, 1'b1, 1'b0, 1'b1);
      check("b2b_spacing", 32'(last_valid_cyc - c1), 32'(FRAME_LEN));
      idle(2);

      // Backpressure: second word dropped, overrun sticks after draining
      run_frame(8'h11, 1'b1, 1'b0, 1'b0);
      run_frame(8'h22, 1'b1, 1'b0, 1'b0);
      q_ready = 1'b1;
      idle(1);
      check("bp_q_kept", 32'(q), 32'h11);

      // Framing error followed immediately by a fresh start bit
      run_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      run_frame(8'h01, 1'b1, 1'b0, 1'b1);
      idle(1);

      // Asynchronous reset in the middle of a frame
      d = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         d = 1'b1;
         tick();
      end
      #3;
      rst_n = 1'b0;
      #1;
      m_q = '0;
      m_valid = 1'b0;
      m_ov = 1'b0;
      check("mid_rst_q", 32'(q), 32'd0);
      check("mid_rst_valid", 32'(q_valid), 32'd0);
      check("mid_rst_ferr", 32'(frame_err), 32'd0);
      check("mid_rst_ovr", 32'(overrun), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      d = 1'b1;
      rst_n = 1'b1;
      idle(1);
      run_frame(8'hFF, 1'b1, 1'b0, 1'b1);
      idle(1);

      if (PAR_EN == 1) begin
         run_frame(8'h07, 1'b1, 1'b0, 1'b1);
         idle(1);
         run_frame(8'h07, 1'b1, 1'b1, 1'b1);
         idle(1);
      end

      // Randomized frames: data, stop bit, parity corruption, backpressure, gaps
      for (int n = 0; n < 40; n++) begin
         rd = DATA_W'($urandom);
         rs = ($urandom_range(0, 4) != 0);
         rf = ($urandom_range(0, 4) == 0);
         rr = 1'($urandom_range(0, 1));
         run_frame(rd, rs, rf, rr);
         idle($urandom_range(0, 2));
      end

      q_ready = 1'b1;
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Bit-serial frame receiver. Samples a single-bit line `d` once per `clk` rising edge, with no oversampling.
- Detects a start bit, shifts in DATA_W data bits LSB-first, then checks a stop bit.
- Presents the assembled word on a one-entry valid/ready output buffer.
- It is the receiving end for the bit streams our flip-flop and shift-register benches drive. It is the building block for the matching serial transmitter tests.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- d  input  1  serial line; idle = 1, start bit = 0, stop bit = 1.
- q  output  DATA_W  received word; held stable while q_valid=1.
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  consumer accepts q when q_valid && q_ready at a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  sticky flag: a good frame completed while the buffer was still full; cleared only by reset.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: q=0, q_valid=0, frame_err=0, overrun=0, busy=0. The FSM goes to IDLE, and the shift register and bit counter are cleared.
- Reset mid-frame aborts the frame immediately. Nothing is delivered.
- FSM states: IDLE, DATA, (PARITY), STOP.
- IDLE: d=0 at an edge is taken as the start bit. The FSM goes to DATA and the bit counter is cleared. d=1 keeps the FSM in IDLE.
- DATA: each edge shifts d into bit position cnt (LSB first) and increments cnt. After DATA_W samples the FSM goes to STOP, or to PARITY when the optional feature is compiled in.
- STOP, d=1: the frame is good and the FSM goes to IDLE.
  - If the buffer is empty, or is being drained at this same edge (q_valid && q_ready), then q is loaded with the shift register and q_valid=1 from this edge onward.
  - Otherwise the buffer is full and not draining. The word is dropped, the old q is kept, and overrun is set.
- STOP, d=0: frame_err pulses high for exactly one cycle. The word is discarded and the FSM returns to IDLE.
  - This d=0 is not reinterpreted as a start bit. The next start bit is searched for from the following edge.
- Latency: with the start bit sampled at edge k, data bits are sampled at edges k+1..k+DATA_W and the stop bit at edge k+DATA_W+1. q_valid is high after edge k+DATA_W+1.
- Back-to-back frames: a start bit may be sampled at edge k+DATA_W+2. There is no mandatory idle gap.
- Handshake:
  - q_valid deasserts at the edge where q_ready=1, unless a new word loads at that same edge, in which case q_valid stays 1 and q updates.
  - q_ready is ignored while q_valid=0.
- Long idle: the line held at 1 indefinitely keeps the FSM in IDLE with no side effects.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - A mismatch is treated exactly like a bad stop bit: frame_err pulses and the word is discarded. The error is reported at the STOP edge, and the FSM still consumes the stop bit.
  - Frame length becomes DATA_W+3 bits.
- Undefined: there is no PARITY state and the frame length is DATA_W+2 bits.

Decomposition:
- Package serial_frame_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1;
  - a function for the counter width, $clog2(DATA_W+1).
- One natural sub-module: serial_frame_rx_buf, the one-entry valid/ready holding register with overrun logic. The FSM plus shift register stays in the top module.

Test Plan:
- Basic frame: reset, then d=1 for 3 cycles, then start 0, data 0xA5 LSB-first (1,0,1,0,0,1,0,1), stop 1, with q_ready=1 → q=0xA5 and q_valid high for one cycle at edge k+9. frame_err=0 and overrun=0.
- Back-to-back: frames 0x3C then 0xC3 with no idle gap, q_ready=1 → two q_valid pulses exactly 10 cycles apart with the correct values.
- Backpressure: hold q_ready=0 and send 0x11 then 0x22 → q stays 0x11 and overrun=1 after the second stop edge. Raising q_ready then clears q_valid, and overrun stays 1.
- Framing error: send 0x5A with stop bit 0 → frame_err high for exactly one cycle and q_valid stays 0. Then send d=0 in the next cycle as a fresh start bit with data 0x01 → q=0x01.
- Reset mid-frame: drop rst_n asynchronously (not aligned to clk) after 4 data bits → all outputs 0 immediately and busy=0. After release a full frame 0xFF is received correctly.
- Parity (with SERIAL_FRAME_RX_PARITY_EN): 0x07 with parity bit 1 → accepted; the same frame with parity bit 0 → frame_err pulse and no q_valid.
